score_display_driver: RTL and testbench

//  Reader/consumer side of the game score path: takes the binary score from the score counter and

---
 rtl/score_display_driver.sv | 221 ++++++++++++++++++++++
 tb/tb_score_display_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_driver.sv
// ---------------------------------------------------------------------------
// score_display_driver
//
// Converts the binary game score to two BCD digits with a sequential
// double-dabble FSM. It also drives a 4-digit, active-low, time-multiplexed
// 7-segment display. Digits 1:0 show the live score. Digits 3:2 are blank,
// or show the high score when SCORE_DISPLAY_HIGH_SCORE_EN is defined.
//
// Optional feature macro: SCORE_DISPLAY_HIGH_SCORE_EN
//   defined   -> high-score register, its own BCD conversion, shown on digits 3:2
//   undefined -> digits 3:2 stay blank
//
// Ports:
//   clkIn        in   system clock
//   reset        in   asynchronous, active-high reset
//   score        in   binary score from the score counter (SCORE_W bits)
//   game_active  in   high while a game is running (used only for the high score)
//   anode        out  digit enables, active low, at most one bit low
//   seg          out  segments {g,f,e,d,c,b,a}, active low
//   score_bcd    out  committed BCD score {tens,ones}
//   busy         out  high while a conversion is in flight
//   bcd_valid    out  one-cycle pulse on each BCD commit
// ---------------------------------------------------------------------------
module score_display_driver #(
  parameter int SCORE_W     = 6,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clkIn,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  input  logic               game_active,
  output logic [3:0]         anode,
  output logic [6:0]         seg,
  output logic [7:0]         score_bcd,
  output logic               busy,
  output logic               bcd_valid
);

  localparam int SR_W  = 8 + SCORE_W;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] ITERS    = CNT_W'(SCORE_W);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} state_t;

  state_t             state, next_state;
  logic [SCORE_W-1:0] last_score;
  logic [SR_W-1:0]    shift_reg, adj_reg;
  logic [CNT_W-1:0]   iter_cnt;
  logic               load_en, shift_en, commit_en, pick_hs;
  logic               live_mismatch, hs_mismatch;
  logic [SCORE_W-1:0] load_value;
  logic               conv_hs;
  logic [REF_W-1:0]   refresh_cnt;
  logic [1:0]         digit_sel;
  logic [6:0]         digit_seg;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // A tens digit of zero is blanked so that single-digit scores look natural.
  function automatic logic [6:0] tens_decode(input logic [3:0] d);
    tens_decode = (d == 4'd0) ? 7'h7F : seg_decode(d);
  endfunction

`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_score, last_high;
  logic [7:0]         high_bcd;
  logic               game_active_d;
  logic               conv_hs_q;

  assign hs_mismatch = (high_score != last_high);
  assign conv_hs     = conv_hs_q;

  // The high score is captured on the falling edge of game_active and is
  // cleared only by reset. Its BCD copy is committed by the shared FSM.
  // conv_hs_q remembers which source the current conversion belongs to.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      high_score    <= '0;
      last_high     <= '0;
      high_bcd      <= 8'h00;
      game_active_d <= 1'b0;
      conv_hs_q     <= 1'b0;
    end else begin
      game_active_d <= game_active;
      if (game_active_d && !game_active && (score > high_score))
        high_score <= score;
      if (state == S_IDLE)
        conv_hs_q <= pick_hs;
      if (load_en && conv_hs_q)
        last_high <= high_score;
      if (commit_en && conv_hs_q)
        high_bcd <= shift_reg[SR_W-1 -: 8];
    end
  end

  assign load_value = conv_hs ? high_score : score;
`else
  logic unused_game_active;
  assign unused_game_active = game_active;
  assign hs_mismatch        = 1'b0;
  assign conv_hs            = 1'b0;
  assign load_value         = score;
`endif

  assign live_mismatch = (score != last_score);

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (live_mismatch || hs_mismatch) next_state = S_LOAD;
      S_LOAD:   next_state = S_SHIFT;
      S_SHIFT:  if (iter_cnt == CNT_W'(1)) next_state = S_COMMIT;
      S_COMMIT: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // The live score wins over the high score when both need converting.
  always_comb begin
    load_en   = (state == S_LOAD);
    shift_en  = (state == S_SHIFT);
    commit_en = (state == S_COMMIT);
    pick_hs   = (state == S_IDLE) && !live_mismatch && hs_mismatch;
  end

  // Double-dabble correction: add 3 to any BCD nibble of 5 or more before shifting.
  always_comb begin
    adj_reg = shift_reg;
    if (shift_reg[SR_W-1 -: 4] >= 4'd5)
      adj_reg[SR_W-1 -: 4] = shift_reg[SR_W-1 -: 4] + 4'd3;
    if (shift_reg[SR_W-5 -: 4] >= 4'd5)
      adj_reg[SR_W-5 -: 4] = shift_reg[SR_W-5 -: 4] + 4'd3;
  end

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      last_score <= '0;
      shift_reg  <= '0;
      iter_cnt   <= '0;
      score_bcd  <= 8'h00;
      busy       <= 1'b0;
      bcd_valid  <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      if (load_en) begin
        shift_reg <= {8'b0, load_value};
        iter_cnt  <= ITERS;
        busy      <= 1'b1;
        if (!conv_hs) last_score <= score;
      end
      if (shift_en) begin
        shift_reg <= {adj_reg[SR_W-2:0], 1'b0};
        iter_cnt  <= iter_cnt - 1'b1;
      end
      if (commit_en) begin
        if (!conv_hs) score_bcd <= shift_reg[SR_W-1 -: 8];
        bcd_valid <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end

  // Segment pattern for the slot that digit_sel currently points at.
  always_comb begin
    digit_seg = 7'h7F;
    case (digit_sel)
      2'd0: digit_seg = seg_decode(score_bcd[3:0]);
      2'd1: digit_seg = tens_decode(score_bcd[7:4]);
`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
      2'd2: digit_seg = seg_decode(high_bcd[3:0]);
      2'd3: digit_seg = tens_decode(high_bcd[7:4]);
`else
      2'd2: digit_seg = 7'h7F;
      2'd3: digit_seg = 7'h7F;
`endif
      default: digit_seg = 7'h7F;
    endcase
  end

  // anode and seg are registered from the same digit_sel value, so they
  // always switch together and never show a glitched mix of digits.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_sel   <= 2'd0;
      anode       <= 4'b1111;
      seg         <= 7'h7F;
    end else begin
      if (refresh_cnt == REF_LAST) begin
        refresh_cnt <= '0;
        digit_sel   <= digit_sel + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      anode <= ~(4'b0001 << digit_sel);
      seg   <= digit_seg;
    end
  end

endmodule

// File: tb/tb_score_display_driver.sv
// ---------------------------------------------------------------------------
// tb_score_display_driver
//
// Directed bench for score_display_driver with a short refresh period.
// When SCORE_DISPLAY_HIGH_SCORE_EN is defined, it also exercises the
// high-score digits. Otherwise it checks that digits 3:2 stay blank.
// ---------------------------------------------------------------------------
module tb_score_display_driver;

  localparam int SCORE_W     = 6;
  localparam int REFRESH_DIV = 4;

  logic               clkIn = 1'b0;
  logic               reset = 1'b0;
  logic [SCORE_W-1:0] score = '0;
  logic               game_active = 1'b0;
  logic [3:0]         anode;
  logic [6:0]         seg;
  logic [7:0]         score_bcd;
  logic               busy;
  logic               bcd_valid;

  int vectors     = 0;
  int miscompares = 0;

  score_display_driver #(
    .SCORE_W     (SCORE_W),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clkIn       (clkIn),
    .reset       (reset),
    .score       (score),
    .game_active (game_active),
    .anode       (anode),
    .seg         (seg),
    .score_bcd   (score_bcd),
    .busy        (busy),
    .bcd_valid   (bcd_valid)
  );

  always #5 clkIn = ~clkIn;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [SCORE_W-1:0] value);
    @(negedge clkIn);
    score = value;
  endtask

  // Returns edges from the first mismatch-seeing edge to the bcd_valid pulse,
  // plus the number of sampled cycles with busy high; lat=0 means timeout.
  task automatic waitValid(output int lat, output int busyCycles);
    lat = 0;
    busyCycles = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clkIn);
      busyCycles += int'(busy);
      if (bcd_valid) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  task automatic checkDigit(input string tag, input int slot, input logic [6:0] expSeg);
    logic [3:0] expAnode;
    expAnode = ~(4'b0001 << slot);
    for (int i = 0; i < 40; i++) begin
      @(negedge clkIn);
      if (anode == expAnode) break;
    end
    checkOutput({tag, "_anode"}, 16'(anode), 16'(expAnode));
    checkOutput(tag, 16'(seg), 16'(expSeg));
  endtask

  initial begin
    int lat, busyCycles, pulses;
    logic [7:0] firstBcd, secondBcd;

    $display("[TB] reset and blank display");
    #1 reset = 1'b1;
    @(negedge clkIn);
    @(negedge clkIn);
    checkOutput("rst_anode", 16'(anode), 16'h000F);
    checkOutput("rst_seg", 16'(seg), 16'h007F);
    checkOutput("rst_bcd", 16'(score_bcd), 16'h0000);
    checkOutput("rst_busy", 16'(busy), 16'h0000);
    checkOutput("rst_valid", 16'(bcd_valid), 16'h0000);
    reset = 1'b0;
    @(negedge clkIn);
    checkOutput("t1_slot0_anode", 16'(anode), 16'h000E);
    checkOutput("t1_slot0_seg", 16'(seg), 16'h0040);
    checkDigit("t1_slot1", 1, 7'h7F);
    checkDigit("t1_slot2", 2, 7'h7F);
    checkDigit("t1_slot3", 3, 7'h7F);

    $display("[TB] score 42");
    applyStimulus(6'd42);
    waitValid(lat, busyCycles);
    checkOutput("t2_latency", 16'(lat), 16'd8);
    checkOutput("t2_busy_cycles", 16'(busyCycles), 16'd7);
    checkOutput("t2_bcd", 16'(score_bcd), 16'h0042);
    @(negedge clkIn);
    checkOutput("t2_valid_one_cycle", 16'(bcd_valid), 16'h0000);
    checkDigit("t2_slot0", 0, 7'h24);
    checkDigit("t2_slot1", 1, 7'h19);

    $display("[TB] score 63 and 9");
    applyStimulus(6'd63);
    waitValid(lat, busyCycles);
    checkOutput("t3_latency63", 16'(lat), 16'd8);
    checkOutput("t3_bcd63", 16'(score_bcd), 16'h0063);
    checkDigit("t3_slot0_63", 0, 7'h30);
    checkDigit("t3_slot1_63", 1, 7'h02);
    applyStimulus(6'd9);
    waitValid(lat, busyCycles);
    checkOutput("t3_bcd9", 16'(score_bcd), 16'h0009);
    checkDigit("t3_slot0_9", 0, 7'h10);
    checkDigit("t3_slot1_9", 1, 7'h7F);

    $display("[TB] score change while busy");
    applyStimulus(6'd10);
    @(negedge clkIn);
    @(negedge clkIn);
    score = 6'd11;
    pulses = 0;
    firstBcd = 8'hFF;
    secondBcd = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkIn);
      if (bcd_valid) begin
        pulses++;
        if (pulses == 1) firstBcd = score_bcd;
        if (pulses == 2) secondBcd = score_bcd;
      end
    end
    checkOutput("t4_pulses", 16'(pulses), 16'd2);
    checkOutput("t4_first", 16'(firstBcd), 16'h0010);
    checkOutput("t4_second", 16'(secondBcd), 16'h0011);
    checkDigit("t4_slot0", 0, 7'h79);
    checkDigit("t4_slot1", 1, 7'h79);

    $display("[TB] reset during conversion");
    applyStimulus(6'd25);
    @(negedge clkIn);
    @(negedge clkIn);
    @(negedge clkIn);
    checkOutput("t5_busy_before", 16'(busy), 16'h0001);
    reset = 1'b1;
    #1;
    checkOutput("t5_anode", 16'(anode), 16'h000F);
    checkOutput("t5_seg", 16'(seg), 16'h007F);
    checkOutput("t5_bcd", 16'(score_bcd), 16'h0000);
    checkOutput("t5_busy", 16'(busy), 16'h0000);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clkIn);
      pulses += int'(bcd_valid);
    end
    checkOutput("t5_no_pulse", 16'(pulses), 16'd0);
    reset = 1'b0;
    waitValid(lat, busyCycles);
    checkOutput("t5_latency", 16'(lat), 16'd8);
    checkOutput("t5_bcd_after", 16'(score_bcd), 16'h0025);
    checkDigit("t5_slot0", 0, 7'h12);
    checkDigit("t5_slot1", 1, 7'h24);

`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
    $display("[TB] high score");
    game_active = 1'b1;
    applyStimulus(6'd42);
    waitValid(lat, busyCycles);
    checkOutput("t6_live42", 16'(score_bcd), 16'h0042);
    @(negedge clkIn);
    game_active = 1'b0;
    waitValid(lat, busyCycles);
    checkOutput("t6_hs_pulse_seen", 16'(lat > 0), 16'h0001);
    checkDigit("t6_slot2", 2, 7'h24);
    checkDigit("t6_slot3", 3, 7'h19);
    game_active = 1'b1;
    applyStimulus(6'd17);
    waitValid(lat, busyCycles);
    checkOutput("t6_live17", 16'(score_bcd), 16'h0017);
    @(negedge clkIn);
    game_active = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clkIn);
      pulses += int'(bcd_valid);
    end
    checkOutput("t6_no_hs_pulse", 16'(pulses), 16'd0);
    checkDigit("t6_slot2_kept", 2, 7'h24);
    checkDigit("t6_slot3_kept", 3, 7'h19);
`else
    $display("[TB] high-score digits blank");
    game_active = 1'b1;
    @(negedge clkIn);
    game_active = 1'b0;
    checkDigit("t6_slot2_blank", 2, 7'h7F);
    checkDigit("t6_slot3_blank", 3, 7'h7F);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
